memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
//   Memory-side end of the CPU address bus. Accepts a request carrying the held
//   memory address, write data, size and direction, inserts WAIT_STATES cycles,
//   then performs a read or write on an internal word-organised RAM.
//   Returns data with a one-cycle ready pulse, or a fault pulse.
// PARAMETERS
//   DEPTH_WORDS  1024  RAM depth in 32-bit words; valid byte addresses 0..4*DEPTH_WORDS-1
//   WAIT_STATES  2     extra cycles between accept and response (0..15)
// PORTS
//   clk              in   1   system clock, rising edge
//   rst_n            in   1   asynchronous active-low reset
//   in_mem_address   in   32  byte address of access
//   in_wdata         in   32  write data; byte/half data in low lanes
//   in_req           in   1   request strobe, sampled only in IDLE
//   in_write         in   1   1=write, 0=read
//   in_size          in   2   00=byte, 01=halfword, 10=word, 11=illegal
//   out_rdata        out  32  read data, zero-extended
//   out_ready        out  1   one-cycle completion pulse
//   out_fault        out  1   one-cycle fault pulse, coincident with out_ready
//   out_busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; out_rdata=0, out_ready=0, out_fault=0, out_busy=0; wait
//     counter=0. RAM contents are not reset.
//   FSM IDLE->WAIT->RESP->IDLE. All outputs are registered.
//   IDLE: at edge k with in_req=1, latch address, wdata, size and write. Go to WAIT
//     with count=WAIT_STATES-1, or go straight to RESP if WAIT_STATES=0.
//   WAIT: decrement count each edge. Go to RESP on the edge where count=0.
//   RESP lasts one cycle. out_ready=1 from edge k+WAIT_STATES to edge
//     k+WAIT_STATES+1. out_busy is high from edge k until RESP exits.
//   Write commits on entry to RESP, using byte enables from size and addr[1:0]
//     (little-endian). Untouched lanes keep their values.
//   Read data: word = RAM[addr>>2]. Byte = lane addr[1:0] in bits[7:0].
//     Half = lane addr[1] in bits[15:0]. Upper bits are 0.
//   out_rdata is loaded on entry to RESP and held until the next response.
//     On a write response out_rdata=0.
//   Fault conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0;
//     addr>>2 >= DEPTH_WORDS.
//   On fault: out_fault=1 with out_ready=1, out_rdata=0, no RAM write.
//   in_req is ignored outside IDLE. A request held high through RESP is accepted
//     at the first IDLE edge after it, so throughput is one access per
//     WAIT_STATES+2 cycles.
//   Inputs are don't-care after acceptance; changing them mid-access has no effect.
//   Reset mid-access (WAIT or RESP before the commit edge): access is abandoned,
//     no write occurs, outputs go to reset values immediately.
//   Read-after-write to the same address returns the newly written data.
// TESTING
//   1 Word write 0x0000_0010 <- 0xDEAD_BEEF, then word read 0x10 -> out_rdata=0xDEADBEEF;
//     out_ready exactly 1 cycle; WAIT_STATES=2 gives ready 2 edges after accept.
//   2 Byte writes 0x11,0x22,0x33,0x44 to addrs 0x20..0x23: word read 0x20 -> 0x44332211;
//     byte read 0x22 -> 0x00000033; half read 0x22 -> 0x00004433.
//   3 Word read at 0x0000_0006, half read at 0x0000_0001, size=11 at 0x0:
//     each -> out_fault=1, out_ready=1, out_rdata=0.
//   4 Word write to 4*DEPTH_WORDS (0x1000) -> fault, no alias. Word read 0x0 is unchanged.
//   5 Write 0xCAFEF00D to 0x30, assert rst_n=0 one cycle after accept, release:
//     all outputs 0; word read 0x30 returns the prior value.
//   6 in_req held high for 10 cycles, WAIT_STATES=0: ready pulses every 2 cycles,
//     busy toggles; rebuild with WAIT_STATES=0 and repeat test 1.

Source files
------------

// File: rtl/memory_responder.sv
// Memory-side responder: latches a CPU request, waits WAIT_STATES cycles, then
// performs a byte/half/word access on an internal word RAM with registered outputs.
module memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_mem_address,
    input  logic [31:0] in_wdata,
    input  logic        in_req,
    input  logic        in_write,
    input  logic [1:0]  in_size,
    output logic [31:0] out_rdata,
    output logic        out_ready,
    output logic        out_fault,
    output logic        out_busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  count_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  size_r;
    logic        write_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic        accept_s;
    logic        enter_resp_s;
    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic [1:0]  eff_size_s;
    logic        eff_write_s;
    logic        fault_s;
    logic [3:0]  be_s;
    logic [31:0] wlanes_s;
    logic [31:0] word_s;
    logic [31:0] rdata_next_s;
    logic        ready_next_s;
    logic        fault_next_s;
    logic        busy_next_s;

    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
        logic in_range;
        in_range = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
        case (size)
            2'b00:   access_fault = !in_range;
            2'b01:   access_fault = !in_range || addr[0];
            2'b10:   access_fault = !in_range || (addr[1:0] != 2'b00);
            default: access_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            2'b00:   byte_enables = 4'b0001 << lane;
            2'b01:   byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_enables = 4'b1111;
            default: byte_enables = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] write_lanes(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            2'b00:   write_lanes = {4{wd[7:0]}};
            2'b01:   write_lanes = {2{wd[15:0]}};
            default: write_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size);
        case (size)
            2'b00:   read_align = {24'd0, word[{lane, 3'b000} +: 8]};
            2'b01:   read_align = lane[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            2'b10:   read_align = word;
            default: read_align = 32'd0;
        endcase
    endfunction

    // With zero wait states the access completes on the accept edge, so use live inputs.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && in_req;
        if (state_r == ST_IDLE) begin
            eff_addr_s  = in_mem_address;
            eff_wdata_s = in_wdata;
            eff_size_s  = in_size;
            eff_write_s = in_write;
        end else begin
            eff_addr_s  = addr_r;
            eff_wdata_s = wdata_r;
            eff_size_s  = size_r;
            eff_write_s = write_r;
        end
        if (rst_n && ((ZERO_WAIT && accept_s) || ((state_r == ST_WAIT) && (count_r == 4'd0)))) begin
            enter_resp_s = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
        end
        fault_s  = access_fault(eff_addr_s, eff_size_s);
        be_s     = byte_enables(eff_addr_s[1:0], eff_size_s);
        wlanes_s = write_lanes(eff_wdata_s, eff_size_s);
        word_s   = mem_r[eff_addr_s[AW+1:2]];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_req) begin
                    if (ZERO_WAIT) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        rdata_next_s = out_rdata;
        ready_next_s = 1'b0;
        fault_next_s = 1'b0;
        busy_next_s  = (state_next_s != ST_IDLE);
        if (enter_resp_s) begin
            ready_next_s = 1'b1;
            fault_next_s = fault_s;
            if (fault_s || eff_write_s) begin
                rdata_next_s = 32'd0;
            end else begin
                rdata_next_s = read_align(word_s, eff_addr_s[1:0], eff_size_s);
            end
        end else begin
            rdata_next_s = out_rdata;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rdata <= 32'd0;
            out_ready <= 1'b0;
            out_fault <= 1'b0;
            out_busy  <= 1'b0;
        end else begin
            out_rdata <= rdata_next_s;
            out_ready <= ready_next_s;
            out_fault <= fault_next_s;
            out_busy  <= busy_next_s;
        end
    end

    // Request capture and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            size_r  <= 2'b00;
            write_r <= 1'b0;
        end else if (accept_s) begin
            count_r <= WAIT_INIT;
            addr_r  <= in_mem_address;
            wdata_r <= in_wdata;
            size_r  <= in_size;
            write_r <= in_write;
        end else if ((state_r == ST_WAIT) && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (enter_resp_s && eff_write_s && !fault_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[eff_addr_s[AW+1:2]][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

endmodule
